// File: rtl/dmac_pkg.sv
// dmac_pkg: shared types and AXI constants for the DMA channel engines.
package dmac_pkg;

    typedef enum logic [1:0] {IDLE, AW, W, B} dmac_state_t;

    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam int         MAX_BURST_DEF  = 16;
    localparam int         PAGE_BYTES     = 4096;

endpackage

// File: rtl/dmac_wr_engine_if.sv
// dmac_wr_engine_if: AXI3 write-channel bundle (AW/W/B) between the write engine and the slave.
interface dmac_wr_engine_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [3:0]            awid_o;
    logic [ADDR_WIDTH-1:0] awaddr_o;
    logic [3:0]            awlen_o;
    logic [2:0]            awsize_o;
    logic [1:0]            awburst_o;
    logic                  awvalid_o;
    logic                  awready_i;
    logic [3:0]            wid_o;
    logic [DATA_WIDTH-1:0] wdata_o;
    logic [3:0]            wstrb_o;
    logic                  wlast_o;
    logic                  wvalid_o;
    logic                  wready_i;
    logic [3:0]            bid_i;
    logic [1:0]            bresp_i;
    logic                  bvalid_i;
    logic                  bready_o;

    modport master (
        output awid_o, awaddr_o, awlen_o, awsize_o, awburst_o, awvalid_o,
        output wid_o, wdata_o, wstrb_o, wlast_o, wvalid_o, bready_o,
        input  awready_i, wready_i, bid_i, bresp_i, bvalid_i
    );

    modport slave (
        input  awid_o, awaddr_o, awlen_o, awsize_o, awburst_o, awvalid_o,
        input  wid_o, wdata_o, wstrb_o, wlast_o, wvalid_o, bready_o,
        output awready_i, wready_i, bid_i, bresp_i, bvalid_i
    );
endinterface

// File: rtl/dmac_burst_calc.sv
// dmac_burst_calc: beats in the next burst = min(remaining, MAX_BURST, beats left in the 4 KB page).
module dmac_burst_calc
    import dmac_pkg::*;
#(
    parameter int REM_WIDTH = 14,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic [11:0]          i_page_off,
    input  logic [REM_WIDTH-1:0] i_rem,
    output logic [4:0]           o_blen
);
    logic [10:0] w_to_page;
    logic [4:0]  w_cap;

    // 1..1024 beats remain in the page since addresses are word aligned
    assign w_to_page = 11'((13'(PAGE_BYTES) - {1'b0, i_page_off}) >> 2);
    assign w_cap     = (w_to_page < 11'(MAX_BURST)) ? w_to_page[4:0] : 5'(MAX_BURST);
    assign o_blen    = (i_rem < REM_WIDTH'(w_cap)) ? i_rem[4:0] : w_cap;
endmodule

// File: rtl/dmac_wr_engine.sv
// dmac_wr_engine: drains the channel FIFO into AXI3 INCR write bursts, one burst outstanding at a time.
module dmac_wr_engine
    import dmac_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16,
    parameter int ID         = 0,
    parameter int MAX_BURST  = MAX_BURST_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] dst_addr_i,
    input  logic [LEN_WIDTH-1:0]  byte_len_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    input  logic                  fifo_empty_i,
    output logic                  fifo_rden_o,
    input  logic [DATA_WIDTH-1:0] fifo_rdata_i,
    dmac_wr_engine_if.master      axi
);
    localparam int RW = LEN_WIDTH - 2;

    dmac_state_t           r_state, w_next;
    logic [ADDR_WIDTH-1:0] r_addr, w_src_addr;
    logic [RW-1:0]         r_rem, w_src_rem;
    logic [4:0]            r_blen, r_beat, w_blen;
    logic                  r_err, r_done;
    logic                  w_aw_hs, w_w_hs, w_b_hs, w_last;

    // In IDLE the calculator sees the new request; in B it sees the post-burst address/remainder
    assign w_src_addr = (r_state == IDLE) ? dst_addr_i : r_addr + ADDR_WIDTH'({r_blen, 2'b00});
    assign w_src_rem  = (r_state == IDLE) ? byte_len_i[LEN_WIDTH-1:2] : r_rem - RW'(r_blen);

    dmac_burst_calc #(.REM_WIDTH(RW), .MAX_BURST(MAX_BURST)) u_calc (
        .i_page_off (w_src_addr[11:0]),
        .i_rem      (w_src_rem),
        .o_blen     (w_blen)
    );

    assign w_aw_hs = axi.awvalid_o & axi.awready_i;
    assign w_w_hs  = axi.wvalid_o & axi.wready_i;
    assign w_b_hs  = axi.bready_o & axi.bvalid_i;
    assign w_last  = r_beat == r_blen - 5'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next        = r_state;
        busy_o        = r_state != IDLE;
        done_o        = r_done;
        err_o         = r_err;
        axi.awid_o    = 4'(ID);
        axi.awaddr_o  = r_addr;
        axi.awlen_o   = 4'(r_blen - 5'd1);
        axi.awsize_o  = AXI_SIZE_4B;
        axi.awburst_o = AXI_BURST_INCR;
        axi.awvalid_o = r_state == AW;
        axi.wid_o     = 4'(ID);
        axi.wdata_o   = fifo_rdata_i;
        axi.wstrb_o   = 4'hF;
        axi.wvalid_o  = (r_state == W) & ~fifo_empty_i;
        axi.wlast_o   = axi.wvalid_o & w_last;
        axi.bready_o  = r_state == B;
        fifo_rden_o   = axi.wvalid_o & axi.wready_i;
        case (r_state)
            IDLE: w_next = (start_i && w_src_rem != '0) ? AW : IDLE;
            AW:   w_next = w_aw_hs ? W : AW;
            W:    w_next = (w_w_hs && w_last) ? B : W;
            B:    w_next = w_b_hs ? ((w_src_rem == '0) ? IDLE : AW) : B;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr <= '0;
            r_rem  <= '0;
            r_blen <= '0;
            r_beat <= '0;
            r_err  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (start_i) begin
                    r_addr <= dst_addr_i;
                    r_rem  <= w_src_rem;
                    r_blen <= w_blen;
                    r_beat <= '0;
                    r_err  <= 1'b0;
                    r_done <= w_src_rem == '0;
                end
                AW: if (w_aw_hs) r_beat <= '0;
                W:  if (w_w_hs) r_beat <= r_beat + 5'd1;
                B:  if (w_b_hs) begin
                    r_err  <= r_err | (axi.bresp_i != AXI_RESP_OKAY);
                    r_addr <= w_src_addr;
                    r_rem  <= w_src_rem;
                    r_blen <= w_blen;
                    r_done <= w_src_rem == '0;
                end
                default: ;
            endcase
        end
    end
endmodule
